// File: rtl/zn_core_multicycle.sv
// Multi-cycle core with parametrised data width and register count.
// Instruction and data ports use req/ack handshakes that tolerate any number of wait states.
module zn_core_multicycle #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int RESET_PC = 0,
    localparam int INSTR_W = 8 + 2*DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [DATA_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [2:0]         flags,
    output logic               halted,
    output logic               illegal,
    output logic [DATA_W-1:0]  dbg_pc,
    output logic [1:0]         dbg_state
);

    localparam int RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [2:0]         flags_q;
    logic               halted_q;
    logic               illegal_q;
    logic               dmem_req_q;
    logic               dmem_we_q;
    logic [DATA_W-1:0]  dmem_addr_q;
    logic [DATA_W-1:0]  dmem_wdata_q;

    logic [7:0]         op;
    logic [DATA_W-1:0]  dst_f;
    logic [DATA_W-1:0]  src_f;
    logic [RI_W-1:0]    rd;
    logic [RI_W-1:0]    rs;
    logic [DATA_W-1:0]  rd_val;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  opb;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  alu_d;
    logic               alu_c_d;
    logic               is_alu;
    logic               alu_wb;
    logic               taken;

    always_comb begin
        op     = ir_q[INSTR_W-1 -: 8];
        dst_f  = ir_q[2*DATA_W-1:DATA_W];
        src_f  = ir_q[DATA_W-1:0];
        rd     = dst_f[RI_W-1:0];
        rs     = src_f[RI_W-1:0];
        rd_val = regs_q[rd];
        rs_val = regs_q[rs];
        is_alu = (op >= 8'h10) && (op <= 8'h1D);
        alu_wb = is_alu && (op != 8'h1A) && (op != 8'h1B);
        // Odd opcodes in the ALU group take the immediate; INC/DEC use a constant 1.
        if (op == 8'h1C || op == 8'h1D) begin
            opb = DATA_W'(1);
        end else if (op[0]) begin
            opb = src_f;
        end else begin
            opb = rs_val;
        end
        sum     = {1'b0, rd_val} + {1'b0, opb};
        diff    = {1'b0, rd_val} - {1'b0, opb};
        alu_d   = sum[DATA_W-1:0];
        alu_c_d = sum[DATA_W];
        case (op)
            8'h12, 8'h13, 8'h1A, 8'h1B, 8'h1D: begin
                alu_d   = diff[DATA_W-1:0];
                alu_c_d = diff[DATA_W];
            end
            8'h14, 8'h15: begin
                alu_d   = rd_val & opb;
                alu_c_d = 1'b0;
            end
            8'h16, 8'h17: begin
                alu_d   = rd_val | opb;
                alu_c_d = 1'b0;
            end
            8'h18, 8'h19: begin
                alu_d   = rd_val ^ opb;
                alu_c_d = 1'b0;
            end
            default: ;
        endcase
        case (op)
            8'h20:   taken = 1'b1;
            8'h21:   taken = flags_q[0];
            8'h22:   taken = ~flags_q[0];
            8'h23:   taken = flags_q[1];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= DATA_W'(RESET_PC);
            ir_q         <= '0;
            flags_q      <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        pc_q    <= pc_q + DATA_W'(1);
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (is_alu) begin
                        if (alu_wb) begin
                            regs_q[rd] <= alu_d;
                        end
                        flags_q <= {alu_d[DATA_W-1], alu_c_d, (alu_d == '0)};
                    end else begin
                        case (op)
                            8'h00: ;
                            8'h01: regs_q[rd] <= src_f;
                            8'h02: regs_q[rd] <= rs_val;
                            8'h03: begin
                                dmem_req_q  <= 1'b1;
                                dmem_we_q   <= 1'b0;
                                dmem_addr_q <= src_f;
                                state_q     <= S_MEM;
                            end
                            8'h04, 8'h05: begin
                                dmem_req_q   <= 1'b1;
                                dmem_we_q    <= 1'b1;
                                dmem_addr_q  <= dst_f;
                                dmem_wdata_q <= (op == 8'h04) ? rs_val : src_f;
                                state_q      <= S_MEM;
                            end
                            8'h20, 8'h21, 8'h22, 8'h23: begin
                                if (taken) begin
                                    pc_q <= dst_f;
                                end
                            end
                            8'hFF: begin
                                halted_q <= 1'b1;
                                state_q  <= S_HALT;
                            end
                            default: begin
                                halted_q  <= 1'b1;
                                illegal_q <= 1'b1;
                                state_q   <= S_HALT;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        if (!dmem_we_q) begin
                            regs_q[rd] <= dmem_rdata;
                        end
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Handshake: a request is held with stable address/data until the cycle its ack is
    // sampled high; an ack seen while the request is low is ignored.
    assign imem_req   = (state_q == S_FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign flags      = flags_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign dbg_pc     = pc_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_zn_core_multicycle.sv
// Bench for zn_core_multicycle: the bench acts as both memories and runs an
// instruction-level model of the ISA in lockstep with the fetch stream.
module tb_zn_core_multicycle;

    localparam int W  = 16;
    localparam int IW = 8 + 2*W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          imem_req, imem_ack;
    logic [W-1:0]  imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [2:0]    flags;
    logic          halted, illegal;
    logic [W-1:0]  dbg_pc;
    logic [1:0]    dbg_state;

    zn_core_multicycle #(.DATA_W(16), .NUM_REGS(4), .RESET_PC(0)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .flags(flags), .halted(halted), .illegal(illegal), .dbg_pc(dbg_pc), .dbg_state(dbg_state)
    );

    // Narrow configuration: zero-wait memories answered combinationally.
    logic        imem_req8, imem_ack8, dmem_req8, dmem_we8, dmem_ack8;
    logic [7:0]  imem_addr8, dmem_addr8, dmem_wdata8, dmem_rdata8, dbg_pc8;
    logic [23:0] imem_rdata8;
    logic [2:0]  flags8;
    logic        halted8, illegal8;
    logic [1:0]  dbg_state8;
    logic [23:0] prog8 [4];
    logic [7:0]  st8 = 8'hAA;

    assign imem_ack8   = imem_req8;
    assign imem_rdata8 = (imem_addr8 < 8'd4) ? prog8[imem_addr8[1:0]] : 24'hFF0000;
    assign dmem_ack8   = dmem_req8;
    assign dmem_rdata8 = 8'h00;
    always @(posedge clk) if (dmem_req8 && dmem_ack8 && dmem_we8) st8 <= dmem_wdata8;

    zn_core_multicycle #(.DATA_W(8), .NUM_REGS(8), .RESET_PC(0)) u_dut8 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8), .imem_ack(imem_ack8),
        .dmem_req(dmem_req8), .dmem_we(dmem_we8), .dmem_addr(dmem_addr8), .dmem_wdata(dmem_wdata8),
        .dmem_rdata(dmem_rdata8), .dmem_ack(dmem_ack8),
        .flags(flags8), .halted(halted8), .illegal(illegal8), .dbg_pc(dbg_pc8), .dbg_state(dbg_state8)
    );

    // ---------------- scoreboard / model state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_pc;
    logic [W-1:0] m_regs [4];
    logic [2:0]   m_flags;
    logic [W-1:0] dmem_m [logic [W-1:0]];
    logic [W-1:0] last_wdata;
    int first_fetch;
    int last_fetch_cyc;
    int pend_extra;
    logic [7:0] rops [0:23] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
                                8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D,
                                8'h20, 8'h21, 8'h22, 8'h23};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [7:0] op, input logic [W-1:0] dst,
                                         input logic [W-1:0] src);
        return {op, dst, src};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_pc = '0;
        m_flags = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        first_fetch = 1;
        pend_extra = 0;
        step();
        check("rst_imem_req", imem_req, 1);
        check("rst_imem_addr", imem_addr, 16'h0000);
        check("rst_halt_ill", {halted, illegal}, 2'b00);
        check("rst_flags", flags, 3'b000);
        check("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 34'h0);
    endtask

    task automatic fetch_one(input logic [IW-1:0] instr, input int iwait);
        int t;
        logic [W-1:0] ea;
        logic stable;
        t = 0;
        @(negedge clk);
        while (!imem_req && t < 100) begin
            if ($urandom_range(0, 2) == 0) begin
                imem_ack = 1'b1;
                imem_rdata = IW'({$urandom, $urandom});
            end
            @(negedge clk);
            imem_ack = 1'b0;
            t++;
        end
        if (!imem_req) begin
            check("fetch_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("fetch_unexpected", 1, 0);
            ea = imem_addr;
        end else begin
            ea = exp_q.pop_front();
            check("fetch_addr", imem_addr, ea);
        end
        check("fetch_dbg_pc", dbg_pc, ea);
        check("fetch_flags", flags, m_flags);
        stable = 1'b1;
        repeat (iwait) begin
            @(negedge clk);
            stable &= imem_req && (imem_addr == ea);
        end
        if (iwait > 0) check("fetch_hold", stable, 1);
        imem_ack = 1'b1;
        imem_rdata = instr;
        step();
        imem_ack = 1'b0;
        imem_rdata = '0;
        if (first_fetch == 0) check("fetch_gap", cyc - last_fetch_cyc, 2 + iwait + pend_extra);
        first_fetch = 0;
        last_fetch_cyc = cyc;
        pend_extra = 0;
    endtask

    task automatic mem_one(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           input logic [W-1:0] rdata, input int dwait);
        int t;
        logic stable;
        t = 0;
        @(negedge clk);
        while (!dmem_req && t < 100) begin
            if ($urandom_range(0, 1) == 0) begin
                dmem_ack = 1'b1;
                dmem_rdata = 16'($urandom);
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            t++;
        end
        if (!dmem_req) begin
            check("mem_timeout", 0, 1);
            return;
        end
        check("mem_we", dmem_we, we);
        check("mem_addr", dmem_addr, addr);
        if (we) check("mem_wdata", dmem_wdata, wdata);
        last_wdata = dmem_wdata;
        stable = 1'b1;
        repeat (dwait) begin
            @(negedge clk);
            stable &= dmem_req && (dmem_we == we) && (dmem_addr == addr) && (!we || dmem_wdata == wdata);
        end
        if (dwait > 0) check("mem_hold", stable, 1);
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        pend_extra = 1 + dwait;
    endtask

    // ---------------- ISA reference model ----------------
    task automatic model_exec(input logic [IW-1:0] instr, output logic is_mem, output logic we,
                              output logic [W-1:0] addr, output logic [W-1:0] wdata,
                              output logic [W-1:0] rdata, output logic halt);
        logic [7:0]   op;
        logic [W-1:0] dst, src;
        logic [1:0]   rd, rs;
        int unsigned  ua, ub, r;
        logic         c;
        op  = instr[IW-1 -: 8];
        dst = instr[2*W-1:W];
        src = instr[W-1:0];
        rd  = dst[1:0];
        rs  = src[1:0];
        is_mem = 0; we = 0; addr = '0; wdata = '0; rdata = '0; halt = 0;
        m_pc = m_pc + 16'd1;
        if (op inside {[8'h10:8'h1D]}) begin
            ua = 32'(m_regs[rd]);
            ub = (op == 8'h1C || op == 8'h1D) ? 32'd1 : (op[0] ? 32'(src) : 32'(m_regs[rs]));
            case (op)
                8'h10, 8'h11, 8'h1C:               begin r = ua + ub; c = (r > 32'hFFFF); end
                8'h12, 8'h13, 8'h1A, 8'h1B, 8'h1D: begin r = ua - ub; c = (ua < ub); end
                8'h14, 8'h15:                      begin r = ua & ub; c = 1'b0; end
                8'h16, 8'h17:                      begin r = ua | ub; c = 1'b0; end
                default:                           begin r = ua ^ ub; c = 1'b0; end
            endcase
            r = r & 32'hFFFF;
            m_flags = {r[15], c, (r == 0)};
            if (op != 8'h1A && op != 8'h1B) m_regs[rd] = r[15:0];
        end else begin
            case (op)
                8'h00: ;
                8'h01: m_regs[rd] = src;
                8'h02: m_regs[rd] = m_regs[rs];
                8'h03: begin
                    is_mem = 1; addr = src;
                    if (!dmem_m.exists(src)) dmem_m[src] = 16'($urandom);
                    rdata = dmem_m[src];
                    m_regs[rd] = rdata;
                end
                8'h04: begin is_mem = 1; we = 1; addr = dst; wdata = m_regs[rs]; dmem_m[dst] = wdata; end
                8'h05: begin is_mem = 1; we = 1; addr = dst; wdata = src; dmem_m[dst] = wdata; end
                8'h20: m_pc = dst;
                8'h21: if (m_flags[0]) m_pc = dst;
                8'h22: if (!m_flags[0]) m_pc = dst;
                8'h23: if (m_flags[1]) m_pc = dst;
                default: halt = 1;
            endcase
        end
        if (!halt) exp_q.push_back(m_pc);
    endtask

    task automatic run_instr(input logic [IW-1:0] instr, input int iwait, input int dwait);
        logic is_mem, we, halt;
        logic [W-1:0] addr, wdata, rdata;
        fetch_one(instr, iwait);
        model_exec(instr, is_mem, we, addr, wdata, rdata, halt);
        if (is_mem) mem_one(we, addr, wdata, rdata, dwait);
    endtask

    task automatic halt_check(input string tag, input logic exp_ill);
        logic quiet;
        logic [W-1:0] pc0;
        step();
        check({tag, "_halted"}, halted, 1);
        check({tag, "_illegal"}, illegal, exp_ill);
        quiet = 1'b1;
        pc0 = dbg_pc;
        repeat (20) begin
            @(negedge clk);
            quiet &= !imem_req && !dmem_req && halted && (dbg_pc == pc0);
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check({tag, "_quiet"}, quiet, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        prog8[0] = {8'h01, 8'h07, 8'hFF};   // LDD R7,0xFF
        prog8[1] = {8'h1C, 8'h07, 8'h00};   // INC R7
        prog8[2] = {8'h04, 8'h20, 8'h07};   // STR [0x20],R7
        prog8[3] = {8'hFF, 8'h00, 8'h00};   // HLT
        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        last_wdata = '0;
        do_reset();

        // add with and without carry-out
        run_instr(mk(8'h01, 16'h0001, 16'h00FF), 0, 0);
        run_instr(mk(8'h11, 16'h0001, 16'h0001), 0, 0);
        step();
        check("add_flags", flags, 3'b000);
        run_instr(mk(8'h04, 16'h0030, 16'h0001), 0, 0);
        check("r1_0100", last_wdata, 16'h0100);
        run_instr(mk(8'h11, 16'h0001, 16'hFF00), 0, 0);
        step();
        check("add_wrap_flags", flags, 3'b011);

        // store with wait states, load back, store register
        run_instr(mk(8'h05, 16'h0010, 16'hBEEF), 0, 3);
        run_instr(mk(8'h03, 16'h0002, 16'h0010), 1, 0);
        run_instr(mk(8'h04, 16'h0011, 16'h0002), 0, 2);
        check("r2_beef", last_wdata, 16'hBEEF);

        // compare and branches
        run_instr(mk(8'h01, 16'h0000, 16'h0005), 0, 0);
        run_instr(mk(8'h1B, 16'h0000, 16'h0005), 0, 0);
        step();
        check("cpd_flags", flags, 3'b001);
        run_instr(mk(8'h21, 16'h0040, 16'h0000), 0, 0);
        step();
        check("jz_taken", imem_addr, 16'h0040);
        run_instr(mk(8'h22, 16'h0080, 16'h0000), 0, 0);
        step();
        check("jnz_not_taken", imem_addr, 16'h0041);
        run_instr(mk(8'h01, 16'h0003, 16'h0000), 0, 0);
        run_instr(mk(8'h1D, 16'h0003, 16'h0000), 0, 0);
        step();
        check("dec_flags", flags, 3'b110);
        run_instr(mk(8'h04, 16'h0012, 16'h0003), 0, 0);
        check("r3_ffff", last_wdata, 16'hFFFF);
        run_instr(mk(8'h04, 16'h0013, 16'h0000), 0, 0);
        check("r0_kept", last_wdata, 16'h0005);

        // randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            logic [7:0]   op;
            logic [W-1:0] d, s;
            op = rops[$urandom_range(0, 23)];
            d = 16'($urandom);
            s = 16'($urandom);
            case ($urandom_range(0, 5))
                0: s = 16'h0000;
                1: s = 16'hFFFF;
                2: s = {14'h0, d[1:0]};
                default: ;
            endcase
            if (op == 8'h03) s = 16'($urandom_range(0, 15));
            if (op == 8'h04 || op == 8'h05) d = 16'($urandom_range(0, 15));
            run_instr(mk(op, d, s), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // reset while a load is waiting for its ack
        do_reset();
        fetch_one(mk(8'h03, 16'h0001, 16'h0005), 0);
        t = 0;
        @(negedge clk);
        while (!dmem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rstmem_pending", dmem_req, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstmem_req_drop", {imem_req, dmem_req}, 2'b00);
        do_reset();
        run_instr(mk(8'h04, 16'h0014, 16'h0001), 0, 0);
        check("rstmem_r1_zero", last_wdata, 16'h0000);

        // illegal opcode, then HLT
        run_instr(mk(8'h01, 16'h0002, 16'h1234), 0, 0);
        run_instr(mk(8'h7F, 16'h0000, 16'h0000), 0, 0);
        halt_check("ill", 1'b1);
        do_reset();
        run_instr(mk(8'hFF, 16'h0000, 16'h0000), 0, 0);
        halt_check("hlt", 1'b0);

        // narrow configuration: INC wraps 0xFF to 0x00
        t = 0;
        while (!halted8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("w8_halted", {halted8, illegal8}, 2'b10);
        check("w8_r7", st8, 8'h00);
        check("w8_flags", flags8, 3'b011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
